elevator_car_scan: RTL

//  Parametrised single-car elevator controller, next generation of the 4-floor car FSM.
//  N floors, multi-request latch (bitmask), SCAN (collect-in-direction) scheduling, configurable

---
 rtl/elevator_pkg.sv | 15 +
 rtl/elevator_req_sched.sv | 28 ++
 rtl/elevator_car_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types: car FSM state encoding and travel-direction constants.
// Used by the car controller and by the dispatcher.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_req_sched.sv
// SCAN request scheduler: finds requests above/below the car and picks the next
// direction, preferring to keep the current sweep direction.
module elevator_req_sched #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  go_up,
  output logic                  go_down
);

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > 32'(current_floor))) req_above = 1'b1;
      if (pending[i] && (i < 32'(current_floor))) req_below = 1'b1;
    end
  end

  assign go_up   = req_above && (dir_up || !req_below);
  assign go_down = req_below && !go_up;

endmodule

// File: rtl/elevator_car_scan.sv
// Single-car elevator controller with multi-request latch and SCAN scheduling.
// Optional DOOR_HOLD_EN macro adds the door_hold input (holds door open, blocks departure).
module elevator_car_scan
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 6,
  parameter int unsigned TIMER_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  move_enable,
`ifdef DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  arrived,
  output logic                  busy
);

  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_CYCLES - 1);

  state_t                  state, state_n;
  logic                    dir_up, dir_up_n;
  logic [TIMER_W-1:0]      move_timer, move_timer_n;
  logic [TIMER_W-1:0]      door_timer, door_timer_n;
  logic [FLOOR_W-1:0]      floor_n, floor_step;
  logic [NUM_FLOORS-1:0]   pending_n;
  logic                    arrived_n, req_err_n;
  logic                    req_ok, req_here, hold;
  logic                    req_above, req_below, go_up, go_down;

  elevator_req_sched #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_sched (
    .pending       (pending),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .req_above     (req_above),
    .req_below     (req_below),
    .go_up         (go_up),
    .go_down       (go_down)
  );

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Next-state, request latch and timer logic
  always_comb begin
    state_n      = state;
    dir_up_n     = dir_up;
    move_timer_n = move_timer;
    door_timer_n = door_timer;
    floor_n      = current_floor;
    pending_n    = pending;
    arrived_n    = 1'b0;
    req_err_n    = 1'b0;

    floor_step = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                    : current_floor - FLOOR_W'(1);
    req_ok   = req_valid && (32'(req_floor) < NUM_FLOORS);
    req_here = req_ok && (req_floor == current_floor) &&
               ((state == IDLE) || (state == DOOR_OPEN));

    if (req_valid && !req_ok) req_err_n = 1'b1;
    if (req_ok && !req_here)  pending_n[req_floor] = 1'b1;

    case (state)
      IDLE: begin
        if (req_here) begin
          state_n      = DOOR_OPEN;
          door_timer_n = '0;
        end else if (pending[current_floor]) begin
          pending_n[current_floor] = 1'b0;
          arrived_n    = 1'b1;
          state_n      = DOOR_OPEN;
          door_timer_n = '0;
        end else if (move_enable && !hold && (pending != '0)) begin
          move_timer_n = '0;
          if (go_up) begin
            state_n  = MOVE_UP;
            dir_up_n = DIR_UP;
          end else if (go_down) begin
            state_n  = MOVE_DOWN;
            dir_up_n = DIR_DOWN;
          end
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (move_enable) begin
          if (move_timer == MOVE_LAST) begin
            floor_n      = floor_step;
            move_timer_n = '0;
            // A request landing on the arrival floor this same edge counts as served
            if (pending_n[floor_step]) begin
              pending_n[floor_step] = 1'b0;
              arrived_n    = 1'b1;
              state_n      = DOOR_OPEN;
              door_timer_n = '0;
            end else if (!((state == MOVE_UP) ? req_above : req_below)) begin
              state_n = IDLE;
            end
          end else begin
            move_timer_n = move_timer + TIMER_W'(1);
          end
        end
      end

      DOOR_OPEN: begin
        if (req_here || hold) begin
          door_timer_n = '0;
        end else if (door_timer == DOOR_LAST) begin
          state_n      = IDLE;
          door_timer_n = '0;
        end else begin
          door_timer_n = door_timer + TIMER_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir_up        <= DIR_UP;
      move_timer    <= '0;
      door_timer    <= '0;
      current_floor <= '0;
      pending       <= '0;
      door_open     <= 1'b1;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      arrived       <= 1'b0;
      req_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      dir_up        <= dir_up_n;
      move_timer    <= move_timer_n;
      door_timer    <= door_timer_n;
      current_floor <= floor_n;
      pending       <= pending_n;
      door_open     <= (state_n == IDLE) || (state_n == DOOR_OPEN);
      moving_up     <= (state_n == MOVE_UP) && move_enable;
      moving_down   <= (state_n == MOVE_DOWN) && move_enable;
      arrived       <= arrived_n;
      req_err       <= req_err_n;
      busy          <= (state_n != IDLE) || (pending_n != '0);
    end
  end

endmodule
